load_store_unit: RTL and testbench

//  Initiator side of the DataMemory port (A/WE/BE/WD/RD).
//  - Takes one byte/half/word load or store per request from the core.
//  - Generates big-endian byte enables and aligns the write lanes.
//  - Splits misaligned accesses into two word accesses.
//  - Merges, sign/zero-extends and returns read data through a req/ready/done handshake.

---
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 tb/tb_load_store_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Initiator side of a big-endian word memory port: byte/half/word loads and stores,
// with misaligned half/word accesses split into two word cycles.
module load_store_unit #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_A,
    output logic        mem_WE,
    output logic [3:0]  mem_BE,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD
);

    typedef enum logic [2:0] {S_IDLE, S_ACC1, S_ACC2, S_CAP, S_DONE} state_t;

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic        split_q;
    logic [3:0]  be_lo;
    logic [31:0] wd_lo;
    logic [31:0] rd0_q;

    logic        misaligned;
    logic        split_in;
    logic        bad_in;
    logic [7:0]  be_base;
    logic [63:0] wd_base;
    logic [7:0]  be_in;
    logic [63:0] wd_in;

    // Accesses are viewed through an 8-byte window spanning two words; the upper
    // half of the window is the first word access, the lower half the second.
    always_comb begin
        misaligned = ((size == 2'b01) && (addr[1:0] == 2'b11)) ||
                     ((size == 2'b10) && (addr[1:0] != 2'b00));
        split_in   = SPLIT_EN && misaligned;
        bad_in     = (size == 2'b11) || (!SPLIT_EN && misaligned);
        case (size)
            2'b00: begin
                be_base = 8'h80;
                wd_base = {wdata[7:0], 56'd0};
            end
            2'b01: begin
                be_base = 8'hC0;
                wd_base = {wdata[15:0], 48'd0};
            end
            default: begin
                be_base = 8'hF0;
                wd_base = {wdata, 32'd0};
            end
        endcase
        be_in = be_base >> addr[1:0];
        wd_in = wd_base >> {addr[1:0], 3'b000};
    end

    logic [63:0] rd_win;
    logic [5:0]  rd_base;
    logic [31:0] rd_top;
    logic [31:0] ld_res;
    logic        sx;

    always_comb begin
        rd_win  = split_q ? {rd0_q, mem_RD} : {mem_RD, 32'd0};
        rd_base = 6'd32 - {1'b0, off_q, 3'b000};
        rd_top  = rd_win[rd_base +: 32];
        sx      = ~uns_q & rd_top[31];
        case (size_q)
            2'b00:   ld_res = {{24{sx}}, rd_top[31:24]};
            2'b01:   ld_res = {{16{sx}}, rd_top[31:16]};
            default: ld_res = rd_top;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            mem_A   <= '0;
            mem_WE  <= 1'b0;
            mem_BE  <= '0;
            mem_WD  <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            split_q <= 1'b0;
            be_lo   <= '0;
            wd_lo   <= '0;
            rd0_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        uns_q   <= uns;
                        off_q   <= addr[1:0];
                        split_q <= split_in;
                        be_lo   <= be_in[3:0];
                        wd_lo   <= wd_in[31:0];
                        ready   <= 1'b0;
                        if (bad_in) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state  <= S_ACC1;
                            err    <= 1'b0;
                            mem_A  <= {addr[31:2], 2'b00};
                            mem_WE <= we;
                            mem_BE <= be_in[7:4];
                            if (we) mem_WD <= wd_in[63:32];
                        end
                    end
                end
                S_ACC1: begin
                    if (split_q) begin
                        state  <= S_ACC2;
                        mem_A  <= mem_A + 32'd4;
                        mem_WE <= we_q;
                        mem_BE <= be_lo;
                        if (we_q) mem_WD <= wd_lo;
                    end else begin
                        state  <= S_CAP;
                        mem_WE <= 1'b0;
                        mem_BE <= '0;
                    end
                end
                S_ACC2: begin
                    state  <= S_CAP;
                    rd0_q  <= mem_RD;
                    mem_WE <= 1'b0;
                    mem_BE <= '0;
                end
                S_CAP: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    if (!we_q) rdata <= ld_res;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    err   <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: bus-level checks per cycle plus a result
// scoreboard popped on each done pulse.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        req2;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_RD;

    logic        ready,  done,  err,  mem_WE;
    logic [31:0] rdata,  mem_A, mem_WD;
    logic [3:0]  mem_BE;
    logic        n_ready, n_done, n_err, n_WE;
    logic [31:0] n_rdata, n_A, n_WD;
    logic [3:0]  n_BE;

    load_store_unit #(.SPLIT_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
        .err(err), .mem_A(mem_A), .mem_WE(mem_WE), .mem_BE(mem_BE),
        .mem_WD(mem_WD), .mem_RD(mem_RD)
    );

    load_store_unit #(.SPLIT_EN(1'b0)) u_nosplit (
        .clk(clk), .rst_n(rst_n), .req(req2), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(n_ready), .done(n_done), .rdata(n_rdata),
        .err(n_err), .mem_A(n_A), .mem_WE(n_WE), .mem_BE(n_BE),
        .mem_WD(n_WD), .mem_RD(mem_RD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        e;
        logic [31:0] r;
        int unsigned lat;
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    logic [31:0] last_rdata = '0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_res(input logic e, input logic [31:0] r, input int unsigned lat);
        exp_t x;
        x.e = e; x.r = r; x.lat = lat;
        sb.push_back(x);
        if (!e && r !== last_rdata) last_rdata = r;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        chk("ready_before_req", {31'd0, ready}, 32'd1);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        step();
        req = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input string tag);
        exp_t x;
        while (done !== 1'b1 && cyc < 12) step();
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            x = sb.pop_front();
            chk({tag, "_done"},    {31'd0, done}, 32'd1);
            chk({tag, "_latency"}, cyc, x.lat);
            chk({tag, "_err"},     {31'd0, err}, {31'd0, x.e});
            chk({tag, "_rdata"},   rdata, x.r);
        end
        step();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; req2 = 1'b0; we = 1'b0; size = '0; uns = 1'b0;
        addr = '0; wdata = '0; mem_RD = '0;
        #12;
        chk("rst_ready",  {31'd0, ready},  32'd1);
        chk("rst_done",   {31'd0, done},   32'd0);
        chk("rst_err",    {31'd0, err},    32'd0);
        chk("rst_rdata",  rdata,           32'd0);
        chk("rst_we",     {31'd0, mem_WE}, 32'd0);
        chk("rst_be",     {28'd0, mem_BE}, 32'd0);
        chk("rst_a",      mem_A,           32'd0);
        chk("rst_wd",     mem_WD,          32'd0);
        rst_n = 1'b1;
        step();

        // store byte at 0
        expect_res(1'b0, last_rdata, 3);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0000, 32'h0000_00FF);
        chk("sb_ready_busy", {31'd0, ready},  32'd0);
        chk("sb_a",  mem_A,           32'h0000_0000);
        chk("sb_be", {28'd0, mem_BE}, 32'h8);
        chk("sb_wd", mem_WD,          32'hFF00_0000);
        chk("sb_we", {31'd0, mem_WE}, 32'd1);
        step();
        chk("sb_cap_we", {31'd0, mem_WE}, 32'd0);
        chk("sb_cap_be", {28'd0, mem_BE}, 32'd0);
        wait_done("store_byte");

        // load byte at 2, signed then unsigned
        mem_RD = 32'h0000_F000;
        expect_res(1'b0, 32'hFFFF_FFF0, 3);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0002, 32'h0);
        chk("lb_be", {28'd0, mem_BE}, 32'h2);
        chk("lb_we", {31'd0, mem_WE}, 32'd0);
        wait_done("load_byte_s");
        expect_res(1'b0, 32'h0000_00F0, 3);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0002, 32'h0);
        wait_done("load_byte_u");

        // split store word at 6; a busy-time request with changed inputs is ignored
        expect_res(1'b0, last_rdata, 4);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'h1122_3344);
        chk("sw_a1",  mem_A,           32'h0000_0004);
        chk("sw_be1", {28'd0, mem_BE}, 32'h3);
        chk("sw_wd1", mem_WD,          32'h0000_1122);
        chk("sw_we1", {31'd0, mem_WE}, 32'd1);
        req = 1'b1; we = 1'b0; size = 2'b00; addr = 32'h0000_0010; wdata = 32'h0;
        step();
        req = 1'b0;
        chk("sw_a2",  mem_A,           32'h0000_0008);
        chk("sw_be2", {28'd0, mem_BE}, 32'hC);
        chk("sw_wd2", mem_WD,          32'h3344_0000);
        chk("sw_we2", {31'd0, mem_WE}, 32'd1);
        wait_done("store_word_split");

        // split load half at 0xFFFFFFFF, wrapping to address 0
        mem_RD = 32'h0000_00AB;
        expect_res(1'b0, 32'h0000_ABCD, 4);
        issue(1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0);
        chk("lh_a1",  mem_A,           32'hFFFF_FFFC);
        chk("lh_be1", {28'd0, mem_BE}, 32'h1);
        step();
        chk("lh_a2",  mem_A,           32'h0000_0000);
        chk("lh_be2", {28'd0, mem_BE}, 32'h8);
        step();
        mem_RD = 32'hCD00_0000;
        wait_done("load_half_split");

        // aligned half at offset 1, sign extended; aligned word
        mem_RD = 32'h0080_7F00;
        expect_res(1'b0, 32'hFFFF_807F, 3);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0021, 32'h0);
        chk("lh1_be", {28'd0, mem_BE}, 32'h6);
        wait_done("load_half_off1");
        mem_RD = 32'h89AB_CDEF;
        expect_res(1'b0, 32'h89AB_CDEF, 3);
        issue(1'b0, 2'b10, 1'b1, 32'h0000_0008, 32'h0);
        chk("lw_be", {28'd0, mem_BE}, 32'hF);
        wait_done("load_word");

        // reserved size: immediate error, no bus activity, rdata held
        expect_res(1'b1, last_rdata, 1);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0004, 32'h0);
        chk("rsv_we", {31'd0, mem_WE}, 32'd0);
        chk("rsv_be", {28'd0, mem_BE}, 32'd0);
        wait_done("reserved_size");

        // misaligned word without splitting
        chk("ns_ready", {31'd0, n_ready}, 32'd1);
        req2 = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h0000_0001; wdata = 32'hDEAD_BEEF;
        step();
        req2 = 1'b0;
        chk("ns_done", {31'd0, n_done}, 32'd1);
        chk("ns_err",  {31'd0, n_err},  32'd1);
        chk("ns_we",   {31'd0, n_WE},   32'd0);
        chk("ns_be",   {28'd0, n_BE},   32'd0);
        step();
        chk("ns_done_pulse", {31'd0, n_done}, 32'd0);

        // reset during first cycle of a split store
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'h5566_7788);
        chk("rm_we_before", {31'd0, mem_WE}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rm_we",    {31'd0, mem_WE}, 32'd0);
        chk("rm_be",    {28'd0, mem_BE}, 32'd0);
        chk("rm_ready", {31'd0, ready},  32'd1);
        chk("rm_done",  {31'd0, done},   32'd0);
        chk("rm_rdata", rdata,           32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rm_no_done", {31'd0, done},   32'd0);
            chk("rm_no_we",   {31'd0, mem_WE}, 32'd0);
        end
        chk("sb_leftover", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
